// File: rtl/clarvi_mem_pkg.sv
// Shared types for the clarvi instruction/data memory arbiter.
package clarvi_mem_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } requester_t;

endpackage

// File: rtl/clarvi_route_fifo.sv
// Small FIFO of requester IDs; records who owns each outstanding read so responses can be routed back.
module clarvi_route_fifo
    import clarvi_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  requester_t    push_id,
    input  logic          pop,
    output requester_t    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    requester_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: nothing is read from it unless count says it is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Round-robin sharing of one Avalon-MM slave between the clarvi instruction and data ports,
// with zero-latency routing of read responses through an ID FIFO.
module clarvi_mem_arbiter
    import clarvi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int MAX_PENDING = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic [ADDR_WIDTH-1:0] avs_instr_address,
    input  logic                  avs_instr_read,
    output logic [31:0]           avs_instr_readdata,
    output logic                  avs_instr_waitrequest,
    output logic                  avs_instr_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] avs_data_address,
    input  logic [3:0]            avs_data_byteenable,
    input  logic                  avs_data_read,
    input  logic                  avs_data_write,
    input  logic [31:0]           avs_data_writedata,
    output logic [31:0]           avs_data_readdata,
    output logic                  avs_data_waitrequest,
    output logic                  avs_data_readdatavalid,

    output logic [ADDR_WIDTH-1:0] avm_mem_address,
    output logic [3:0]            avm_mem_byteenable,
    output logic                  avm_mem_read,
    output logic                  avm_mem_write,
    output logic [31:0]           avm_mem_writedata,
    input  logic [31:0]           avm_mem_readdata,
    input  logic                  avm_mem_waitrequest,
    input  logic                  avm_mem_readdatavalid,

    output logic                  err_orphan_response
);

    localparam int CW = $clog2(MAX_PENDING) + 1;

    requester_t    grant;
    requester_t    last_grant;
    requester_t    lock_grant;
    requester_t    fifo_head;
    logic          lock;
    logic          req_i;
    logic          req_d;
    logic          cmd_read;
    logic          cmd_write;
    logic          cmd_valid;
    logic          rd_block;
    logic          accept;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic [CW-1:0] fifo_count;

    assign req_i = avs_instr_read;
    assign req_d = avs_data_read | avs_data_write;

    // Contention goes to whoever was not served last; a stalled command keeps its grant.
    always_comb begin
        grant = REQ_INSTR;
        if (lock) begin
            grant = lock_grant;
        end else if (req_i && req_d) begin
            grant = (last_grant == REQ_DATA) ? REQ_INSTR : REQ_DATA;
        end else if (req_d) begin
            grant = REQ_DATA;
        end
    end

    always_comb begin
        if (grant == REQ_DATA) begin
            avm_mem_address    = avs_data_address;
            avm_mem_byteenable = avs_data_byteenable;
            avm_mem_writedata  = avs_data_writedata;
            cmd_read           = avs_data_read;
            cmd_write          = avs_data_write;
        end else begin
            avm_mem_address    = avs_instr_address;
            avm_mem_byteenable = 4'hF;
            avm_mem_writedata  = 32'h0;
            cmd_read           = avs_instr_read;
            cmd_write          = 1'b0;
        end
    end

    // Full FIFO blocks reads even if a response pops this cycle.
    assign cmd_valid     = cmd_read | cmd_write;
    assign rd_block      = cmd_read && (fifo_count == CW'(MAX_PENDING));
    assign avm_mem_read  = cmd_read && !rd_block;
    assign avm_mem_write = cmd_write;
    assign accept        = cmd_valid && !avm_mem_waitrequest && !rd_block;

    assign avs_instr_waitrequest = !(req_i && grant == REQ_INSTR) || avm_mem_waitrequest || rd_block;
    assign avs_data_waitrequest  = !(req_d && grant == REQ_DATA)  || avm_mem_waitrequest || rd_block;

    assign fifo_pop                = avm_mem_readdatavalid && !fifo_empty;
    assign avs_instr_readdatavalid = fifo_pop && (fifo_head == REQ_INSTR);
    assign avs_data_readdatavalid  = fifo_pop && (fifo_head == REQ_DATA);
    assign avs_instr_readdata      = avm_mem_readdata;
    assign avs_data_readdata       = avm_mem_readdata;

    clarvi_route_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_route_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (accept && cmd_read),
        .push_id (grant),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full_unused),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant          <= REQ_DATA;
            lock_grant          <= REQ_DATA;
            lock                <= 1'b0;
            err_orphan_response <= 1'b0;
        end else begin
            lock       <= cmd_valid && !accept;
            lock_grant <= grant;
            if (accept) begin
                last_grant <= grant;
            end
            if (avm_mem_readdatavalid && fifo_empty) begin
                err_orphan_response <= 1'b1;
            end
        end
    end

endmodule
